// File: rtl/bit_stream_feeder.sv
// bit_stream_feeder
//   Serializes parallel words into a one-bit stream for the pattern detector.
//   Words arrive over valid/ready. A one-entry holding buffer keeps
//   consecutive words streaming with no bubble. pause_i inserts idle cycles
//   (valid_o=0) without losing the pending bit.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   data_i        parallel word, taken when data_valid_i && data_ready_o
//   data_valid_i  upstream word valid
//   data_ready_o  buffer empty (registered)
//   pause_i       stall the serial output
//   d_o           serial bit (registered)
//   valid_o       d_o carries a real bit this cycle (registered)
//   word_done_o   pulse with the last bit of each word (registered)
//   busy_o        buffer or shifter holds undelivered bits (registered)
module bit_stream_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic             pause_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] buf_q;
    logic             buf_full_q, buf_full_n;
    logic [WIDTH-1:0] sh_q;
    logic             sh_full_q;   // shifter still holds bits of a word
    logic [CW-1:0]    cnt_q;

    logic             hs, last;
    logic             start;       // load a word and emit its first bit now
    logic             emit;        // emit the next bit from the shifter
    logic             reload_buf;  // last bit out; next word comes from buf
    logic             reload_in;   // last bit out; next word bypasses buf
    logic             wr_buf;
    logic [WIDTH-1:0] word_in;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // A buffered word is always older than one on data_i.
    assign word_in = buf_full_q ? buf_q : data_i;

    always_comb begin
        hs         = data_valid_i && data_ready_o;
        last       = (cnt_q == LAST);
        start      = 1'b0;
        emit       = 1'b0;
        reload_buf = 1'b0;
        reload_in  = 1'b0;
        wr_buf     = 1'b0;
        buf_full_n = buf_full_q;
        state_n    = state_q;
        if (!sh_full_q) begin
            // Idle, or the cycle right after a drained word: start the next
            // word the same edge it becomes available.
            start   = !pause_i && (buf_full_q || hs);
            state_n = start ? SHIFT : IDLE;
            if (start && buf_full_q) begin
                wr_buf     = hs;
                buf_full_n = hs;
            end else if (!start) begin
                wr_buf     = hs;
                buf_full_n = buf_full_q || hs;
            end
            // start with an empty buffer: the word goes straight to sh
        end else begin
            state_n = SHIFT;
            emit    = !pause_i;
            if (emit && last && buf_full_q) begin
                reload_buf = 1'b1;
                wr_buf     = hs;
                buf_full_n = hs;
            end else if (emit && last && hs) begin
                reload_in = 1'b1;
            end else begin
                wr_buf     = hs;
                buf_full_n = buf_full_q || hs;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            sh_q         <= '0;
            sh_full_q    <= 1'b0;
            cnt_q        <= '0;
            d_o          <= 1'b0;
            valid_o      <= 1'b0;
            word_done_o  <= 1'b0;
            busy_o       <= 1'b0;
            data_ready_o <= 1'b1;
        end else begin
            state_q      <= state_n;
            buf_full_q   <= buf_full_n;
            data_ready_o <= !buf_full_n;
            busy_o       <= buf_full_n || (state_n == SHIFT);
            valid_o      <= start || emit;
            word_done_o  <= emit && last;
            if (wr_buf)
                buf_q <= data_i;
            if (start) begin
                d_o       <= head(word_in);
                sh_q      <= adv(word_in);
                cnt_q     <= CW'(1);
                sh_full_q <= 1'b1;
            end else if (emit) begin
                d_o <= head(sh_q);
                if (last) begin
                    cnt_q <= '0;
                    if (reload_buf)
                        sh_q <= buf_q;
                    else if (reload_in)
                        sh_q <= data_i;
                    else
                        sh_full_q <= 1'b0;
                end else begin
                    sh_q  <= adv(sh_q);
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_stream_feeder.sv
// Bench for bit_stream_feeder: a WIDTH=8 MSB-first instance checked against a
// bit-queue reference model on every cycle, plus a WIDTH=4 LSB-first instance.
module tb_bit_stream_feeder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] data8;
    logic       dv8, rdy8, pause8, d8, v8, wd8, busy8;
    logic [3:0] data4;
    logic       dv4, rdy4, pause4, d4, v4, wd4, busy4;

    bit_stream_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data8), .data_valid_i(dv8),
        .data_ready_o(rdy8), .pause_i(pause8), .d_o(d8), .valid_o(v8),
        .word_done_o(wd8), .busy_o(busy8));

    bit_stream_feeder #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data4), .data_valid_i(dv4),
        .data_ready_o(rdy4), .pause_i(pause4), .d_o(d4), .valid_o(v4),
        .word_done_o(wd4), .busy_o(busy4));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: every accepted word appends its bits in send order
    bit         bq[$];
    int         nbits = 0;
    bit         have_prev = 0;
    bit         p_hs, p_pause;
    logic [7:0] p_data;

    // observed streams
    bit ob[$];
    int ot[$];
    bit ow[$];
    bit ob4[$];
    bit ow4[$];

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_bits;  // bit 7 = first bit on the wire
        logic [7:0] exp_done;  // bit 7 = first bit's word_done
    } vec_t;
    vec_t tv[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon();
        bit ev, eb;
        cyc++;
        if (!rst_n) begin
            bq.delete();
            nbits = 0;
            chk("rst_valid", v8, 0);
            chk("rst_done", wd8, 0);
            chk("rst_busy", busy8, 0);
            chk("rst_ready", rdy8, 1);
        end else if (have_prev) begin
            if (p_hs)
                for (int i = 7; i >= 0; i--) bq.push_back(p_data[i]);
            chk("busy", busy8, bq.size() > 0);
            ev = !p_pause && (bq.size() > 0);
            chk("valid", v8, ev);
            if (ev) begin
                eb = bq.pop_front();
                nbits++;
                chk("bit", d8, eb);
                chk("done", wd8, (nbits % 8) == 0);
            end else begin
                chk("done_idle", wd8, 0);
            end
        end
        if (rst_n && v8) begin
            ob.push_back(d8);
            ot.push_back(cyc);
            ow.push_back(wd8);
        end
        if (rst_n && v4) begin
            ob4.push_back(d4);
            ow4.push_back(wd4);
        end
        p_hs      = dv8 && rdy8;
        p_data    = data8;
        p_pause   = pause8;
        have_prev = rst_n;
    endtask

    // inputs change at posedge+1; outputs are observed at the negedge
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        ob.delete(); ot.delete(); ow.delete(); ob4.delete(); ow4.delete();
    endtask

    task automatic send8(input logic [7:0] w);
        int n = 0;
        data8 = w;
        dv8   = 1'b1;
        while (!rdy8 && n < 50) begin tick(); n++; end
        if (n >= 50) chk("hs8_timeout", 0, 1);
        tick();
        dv8 = 1'b0;
    endtask

    task automatic send4(input logic [3:0] w);
        int n = 0;
        data4 = w;
        dv4   = 1'b1;
        while (!rdy4 && n < 50) begin tick(); n++; end
        if (n >= 50) chk("hs4_timeout", 0, 1);
        tick();
        dv4 = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((busy8 || busy4) && n < 200) begin tick(); n++; end
        if (n >= 200) chk("quiet_timeout", 0, 1);
        tick();
    endtask

    function automatic int ndone();
        int s = 0;
        foreach (ow[i]) s += ow[i];
        return s;
    endfunction

    initial begin
        logic [7:0]  cb, cd;
        logic [23:0] e24;
        logic [3:0]  c4;
        int          n;

        tv[0] = '{8'hD8, 8'b11011000, 8'b00000001};
        tv[1] = '{8'hFF, 8'b11111111, 8'b00000001};
        tv[2] = '{8'h00, 8'b00000000, 8'b00000001};
        tv[3] = '{8'hA5, 8'b10100101, 8'b00000001};
        tv[4] = '{8'h01, 8'b00000001, 8'b00000001};

        rst_n = 1'b0;
        dv8 = 0; data8 = 0; pause8 = 0;
        dv4 = 0; data4 = 0; pause4 = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single words, no pause
        for (int k = 0; k < 5; k++) begin
            clear_obs();
            send8(tv[k].word);
            n = 0;
            while (!wd8 && n < 40) begin tick(); n++; end
            chk("tv_done_seen", wd8, 1);
            chk("tv_busy_at_done", busy8, 1);
            tick();
            chk("tv_busy_after", busy8, 0);
            chk("tv_valid_after", v8, 0);
            tick();
            chk("tv_count", ob.size(), 8);
            if (ob.size() == 8) begin
                for (int i = 0; i < 8; i++) begin
                    cb[7-i] = ob[i];
                    cd[7-i] = ow[i];
                end
                chk("tv_bits", cb, tv[k].exp_bits);
                chk("tv_done_pos", cd, tv[k].exp_done);
            end
        end

        // back-to-back FF then 00
        clear_obs();
        data8 = 8'hFF; dv8 = 1'b1;
        tick();
        data8 = 8'h00;
        n = 0;
        while (!rdy8 && n < 50) begin tick(); n++; end
        tick();
        chk("t2_ready_drop", rdy8, 0);
        dv8 = 1'b0;
        wait_quiet();
        chk("t2_count", ob.size(), 16);
        if (ob.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("t2_bit", ob[i], (i < 8) ? 1 : 0);
            chk("t2_contig", ot[15] - ot[0], 15);
            chk("t2_done7", ow[7], 1);
            chk("t2_done15", ow[15], 1);
        end
        chk("t2_ndone", ndone(), 2);

        // pause for 3 cycles after the third bit
        clear_obs();
        send8(8'hB4);
        tick(); tick();
        pause8 = 1'b1;
        tick(); tick(); tick();
        pause8 = 1'b0;
        wait_quiet();
        chk("t3_count", ob.size(), 8);
        if (ob.size() == 8) begin
            for (int i = 0; i < 8; i++) cb[7-i] = ob[i];
            chk("t3_bits", cb, 8'hB4);
            chk("t3_head", ot[2] - ot[0], 2);
            chk("t3_gap", ot[3] - ot[2], 4);
            chk("t3_tail", ot[7] - ot[3], 4);
        end

        // third word waits while shifter and buffer are full
        clear_obs();
        send8(8'h3C);
        send8(8'hE1);
        data8 = 8'h96; dv8 = 1'b1;
        chk("t4_ready_low", rdy8, 0);
        n = 0;
        while (!rdy8 && n < 50) begin tick(); n++; end
        tick();
        dv8 = 1'b0;
        wait_quiet();
        chk("t4_count", ob.size(), 24);
        if (ob.size() == 24) begin
            e24 = 24'h3CE196;
            for (int i = 0; i < 24; i++) chk("t4_bit", ob[i], e24[23-i]);
            chk("t4_contig", ot[23] - ot[0], 23);
        end
        chk("t4_ndone", ndone(), 3);

        // asynchronous reset mid-word
        clear_obs();
        send8(8'hC3);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", v8, 0);
        chk("t5_done", wd8, 0);
        chk("t5_busy", busy8, 0);
        chk("t5_ready", rdy8, 1);
        tick();
        rst_n = 1'b1;
        clear_obs();
        send8(8'h5A);
        wait_quiet();
        chk("t5_count", ob.size(), 8);
        if (ob.size() == 8) begin
            for (int i = 0; i < 8; i++) cb[7-i] = ob[i];
            chk("t5_bits", cb, 8'h5A);
        end
        chk("t5_ndone", ndone(), 1);

        // LSB-first, WIDTH=4
        clear_obs();
        send4(4'b0011);
        wait_quiet();
        chk("t6a_count", ob4.size(), 4);
        if (ob4.size() == 4) begin
            for (int i = 0; i < 4; i++) c4[3-i] = ob4[i];
            chk("t6a_bits", c4, 4'b1100);
            chk("t6a_done", ow4[3], 1);
        end
        clear_obs();
        send4(4'b1010);
        wait_quiet();
        chk("t6b_count", ob4.size(), 4);
        if (ob4.size() == 4) begin
            for (int i = 0; i < 4; i++) c4[3-i] = ob4[i];
            chk("t6b_bits", c4, 4'b0101);
        end

        // random traffic against the bit-queue model
        for (int i = 0; i < 500; i++) begin
            dv8    = ($urandom % 2) == 0;
            data8  = 8'($urandom);
            pause8 = ($urandom % 4) == 0;
            tick();
        end
        dv8 = 1'b0;
        pause8 = 1'b0;
        wait_quiet();
        chk("rand_drained", bq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
